// File: rtl/if_stage_pkg.sv
// Shared types and constants for the RV64I instruction-fetch stage.
// State encoding, bus widths and the default boot address live here.
package if_stage_pkg;

    localparam int REG_BUS  = 64;
    localparam int INST_BUS = 32;

    localparam logic [REG_BUS-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        IF_BOOT = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2,
        IF_HOLD = 2'd3
    } if_state_e;

    // Instruction addresses are always word aligned; low bits of a target are dropped.
    function automatic logic [REG_BUS-1:0] align_word(input logic [REG_BUS-1:0] addr);
        return addr & ~(REG_BUS'(3));
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's memory, redirect and decode-side signals.
// The master modport is the fetch stage; the slave modport is its surroundings.
interface if_stage_if #(
    parameter int PC_W = if_stage_pkg::REG_BUS
) ();

    // instruction-memory request / response
    logic                              imem_req_valid;
    logic                              imem_req_ready;
    logic [PC_W-1:0]                   imem_req_addr;
    logic                              imem_resp_valid;
    logic [if_stage_pkg::INST_BUS-1:0] imem_resp_data;

    // execute-stage redirect
    logic                              redirect_valid;
    logic [PC_W-1:0]                   redirect_pc;

    // decode-side handoff
    logic                              id_valid;
    logic                              id_ready;
    logic [if_stage_pkg::INST_BUS-1:0] id_inst;
    logic [PC_W-1:0]                   id_inst_addr;
    logic [63:0]                       fetch_cnt;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  redirect_valid,
        input  redirect_pc,
        output id_valid,
        input  id_ready,
        output id_inst,
        output id_inst_addr,
        output fetch_cnt
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_resp_valid,
        output imem_resp_data,
        output redirect_valid,
        output redirect_pc,
        input  id_valid,
        output id_ready,
        input  id_inst,
        input  id_inst_addr,
        input  fetch_cnt
    );

endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding 32-bit fetch, holds the word for decode,
// and squashes in-flight or held fetches when execute redirects the PC.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                      PC_W     = REG_BUS,
    parameter logic [REG_BUS-1:0]      RESET_PC = RESET_PC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    if_stage_if.master bus
);

    if_state_e             state_reg, state_next;
    logic [PC_W-1:0]       pc_reg, pc_next;
    logic                  drop_reg, drop_next;
    logic [INST_BUS-1:0]   inst_reg, inst_next;
    logic [PC_W-1:0]       inst_addr_reg, inst_addr_next;
    logic [63:0]           cnt_reg, cnt_next;

    logic                  req_valid;
    logic                  id_valid;
    logic [PC_W-1:0]       redirect_target;

    assign redirect_target = bus.redirect_pc & ~(PC_W'(3));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IF_BOOT;
            pc_reg        <= PC_W'(RESET_PC);
            drop_reg      <= 1'b0;
            inst_reg      <= '0;
            inst_addr_reg <= '0;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            drop_reg      <= drop_next;
            inst_reg      <= inst_next;
            inst_addr_reg <= inst_addr_next;
            cnt_reg       <= cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        drop_next      = drop_reg;
        inst_next      = inst_reg;
        inst_addr_next = inst_addr_reg;
        cnt_next       = cnt_reg;
        req_valid      = 1'b0;
        id_valid       = 1'b0;

        case (state_reg)
            IF_BOOT: begin
                state_next = IF_REQ;
            end

            IF_REQ: begin
                req_valid = 1'b1;
                if (bus.imem_req_ready) begin
                    state_next = IF_WAIT;
                    // An accepted request whose address is already stale must be squashed on return.
                    drop_next  = bus.redirect_valid;
                end
            end

            IF_WAIT: begin
                if (bus.imem_resp_valid) begin
                    if (drop_reg || bus.redirect_valid) begin
                        drop_next  = 1'b0;
                        state_next = IF_REQ;
                    end else begin
                        inst_next      = bus.imem_resp_data;
                        inst_addr_next = pc_reg;
                        pc_next        = pc_reg + PC_W'(4);
                        state_next     = IF_HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    drop_next = 1'b1;
                end
            end

            IF_HOLD: begin
                // A same-cycle redirect kills the held word before decode can take it.
                id_valid = ~bus.redirect_valid;
                if (bus.redirect_valid) begin
                    state_next = IF_REQ;
                end else if (bus.id_ready) begin
                    cnt_next   = cnt_reg + 64'd1;
                    state_next = IF_REQ;
                end
            end

            default: begin
                state_next = IF_BOOT;
            end
        endcase

        if (bus.redirect_valid) begin
            pc_next = redirect_target;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = req_valid ? pc_reg : '0;
    assign bus.id_valid       = id_valid;
    assign bus.id_inst        = inst_reg;
    assign bus.id_inst_addr   = inst_addr_reg;
    assign bus.fetch_cnt      = cnt_reg;

endmodule

// File: tb/tb_if_stage.sv
// Cycle-by-cycle directed bench for if_stage: each vector drives one cycle of inputs
// and states the outputs expected in that cycle.
module tb_if_stage;
    import if_stage_pkg::*;

    logic clk;
    logic rst;

    if_stage_if bus ();

    if_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rdv;
        logic [63:0] rpc;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        idr;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_idv;
        logic [31:0] e_inst;
        logic [63:0] e_iaddr;
        logic [63:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(string n, logic rdv, logic [63:0] rpc, logic rdy, logic rv,
                                logic [31:0] rd, logic idr, logic eq, logic [63:0] ea,
                                logic ev, logic [31:0] ei, logic [63:0] eia, logic [63:0] ec);
        vec_t v;
        v.name = n; v.rdv = rdv; v.rpc = rpc; v.rdy = rdy; v.rv = rv; v.rd = rd; v.idr = idr;
        v.e_req = eq; v.e_addr = ea; v.e_idv = ev; v.e_inst = ei; v.e_iaddr = eia; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic check_outputs(input string nm, input logic eq, input logic [63:0] ea,
                                 input logic ev, input logic [31:0] ei,
                                 input logic [63:0] eia, input logic [63:0] ec);
        chk({nm, ".req_valid"}, 64'(bus.imem_req_valid), 64'(eq));
        chk({nm, ".req_addr"},  bus.imem_req_addr, ea);
        chk({nm, ".id_valid"},  64'(bus.id_valid), 64'(ev));
        chk({nm, ".id_inst"},   64'(bus.id_inst), 64'(ei));
        chk({nm, ".id_addr"},   bus.id_inst_addr, eia);
        chk({nm, ".fetch_cnt"}, bus.fetch_cnt, ec);
    endtask

    // Called at a falling edge: drive, settle, compare, then advance one full cycle.
    task automatic apply_vec(input vec_t v);
        bus.redirect_valid  = v.rdv;
        bus.redirect_pc     = v.rpc;
        bus.imem_req_ready  = v.rdy;
        bus.imem_resp_valid = v.rv;
        bus.imem_resp_data  = v.rd;
        bus.id_ready        = v.idr;
        #1;
        check_outputs(v.name, v.e_req, v.e_addr, v.e_idv, v.e_inst, v.e_iaddr, v.e_cnt);
        $display("vec %-12s req=%0b addr=%h idv=%0b inst=%h iaddr=%h cnt=%0d",
                 v.name, bus.imem_req_valid, bus.imem_req_addr, bus.id_valid,
                 bus.id_inst, bus.id_inst_addr, bus.fetch_cnt);
        @(negedge clk);
    endtask

    localparam logic [31:0] I0 = 32'h0010_0093;
    localparam logic [31:0] I1 = 32'h0020_8113;
    localparam logic [31:0] I2 = 32'h00c0_0513;
    localparam logic [31:0] I3 = 32'h0000_0013;
    localparam logic [31:0] I4 = 32'h00a0_0593;
    localparam logic [31:0] I5 = 32'h0000_0073;
    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.id_ready        = 1'b0;

        //        name          rdv rpc                    rdy rv rd            idr eq ea                     ev ei  eia                    ec
        vecs.push_back(mk("boot",      0, 0,                     0, 0, 0,            1,  0, 0,                     0, 0,  0,                     0));
        vecs.push_back(mk("req0",      0, 0,                     1, 0, 0,            1,  1, 64'h8000_0000,         0, 0,  0,                     0));
        vecs.push_back(mk("wait0",     0, 0,                     0, 1, I0,           1,  0, 0,                     0, 0,  0,                     0));
        vecs.push_back(mk("hold0",     0, 0,                     0, 0, 0,            1,  0, 0,                     1, I0, 64'h8000_0000,         0));
        vecs.push_back(mk("req1",      0, 0,                     1, 0, 0,            1,  1, 64'h8000_0004,         0, I0, 64'h8000_0000,         1));
        vecs.push_back(mk("wait1",     0, 0,                     0, 1, I1,           1,  0, 0,                     0, I0, 64'h8000_0000,         1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk("stall",  0, 0,                     0, 0, 0,            0,  0, 0,                     1, I1, 64'h8000_0004,         1));
        vecs.push_back(mk("hold1",     0, 0,                     0, 0, 0,            1,  0, 0,                     1, I1, 64'h8000_0004,         1));
        vecs.push_back(mk("req2",      0, 0,                     1, 0, 0,            1,  1, 64'h8000_0008,         0, I1, 64'h8000_0004,         2));
        vecs.push_back(mk("wait_rd",   1, 64'h8000_0102,         0, 0, 0,            1,  0, 0,                     0, I1, 64'h8000_0004,         2));
        vecs.push_back(mk("wait_idle", 0, 0,                     0, 0, 0,            1,  0, 0,                     0, I1, 64'h8000_0004,         2));
        vecs.push_back(mk("wait_drop", 0, 0,                     0, 1, 32'hDEADBEEF, 1,  0, 0,                     0, I1, 64'h8000_0004,         2));
        vecs.push_back(mk("req3",      0, 0,                     1, 0, 0,            1,  1, 64'h8000_0100,         0, I1, 64'h8000_0004,         2));
        vecs.push_back(mk("wait3",     0, 0,                     0, 1, I2,           1,  0, 0,                     0, I1, 64'h8000_0004,         2));
        vecs.push_back(mk("hold_rd",   1, 64'h8000_0200,         0, 0, 0,            1,  0, 0,                     0, I2, 64'h8000_0100,         2));
        vecs.push_back(mk("nrdy_a",    0, 0,                     0, 0, 0,            1,  1, 64'h8000_0200,         0, I2, 64'h8000_0100,         2));
        vecs.push_back(mk("nrdy_b",    0, 0,                     0, 0, 0,            1,  1, 64'h8000_0200,         0, I2, 64'h8000_0100,         2));
        vecs.push_back(mk("nrdy_rd",   1, 64'h8000_0307,         0, 0, 0,            1,  1, 64'h8000_0200,         0, I2, 64'h8000_0100,         2));
        vecs.push_back(mk("nrdy_d",    0, 0,                     0, 0, 0,            1,  1, 64'h8000_0304,         0, I2, 64'h8000_0100,         2));
        vecs.push_back(mk("req4",      0, 0,                     1, 0, 0,            1,  1, 64'h8000_0304,         0, I2, 64'h8000_0100,         2));
        vecs.push_back(mk("wait4a",    0, 0,                     1, 0, 0,            1,  0, 0,                     0, I2, 64'h8000_0100,         2));
        vecs.push_back(mk("wait4b",    0, 0,                     0, 1, I3,           1,  0, 0,                     0, I2, 64'h8000_0100,         2));
        vecs.push_back(mk("hold4",     0, 0,                     0, 0, 0,            1,  0, 0,                     1, I3, 64'h8000_0304,         2));
        vecs.push_back(mk("req_rd",    1, 64'h8000_0400,         1, 0, 0,            1,  1, 64'h8000_0308,         0, I3, 64'h8000_0304,         3));
        vecs.push_back(mk("wait_dr2",  0, 0,                     0, 1, 32'hBAD0BAD0, 1,  0, 0,                     0, I3, 64'h8000_0304,         3));
        vecs.push_back(mk("req6",      0, 0,                     1, 0, 0,            1,  1, 64'h8000_0400,         0, I3, 64'h8000_0304,         3));
        vecs.push_back(mk("wait6",     0, 0,                     0, 1, I4,           1,  0, 0,                     0, I3, 64'h8000_0304,         3));
        vecs.push_back(mk("hold6",     0, 0,                     0, 0, 0,            1,  0, 0,                     1, I4, 64'h8000_0400,         3));
        vecs.push_back(mk("req7",      0, 0,                     1, 0, 0,            1,  1, 64'h8000_0404,         0, I4, 64'h8000_0400,         4));
        vecs.push_back(mk("wait_rsp",  1, 64'h8000_0500,         0, 1, 32'h11111111, 1,  0, 0,                     0, I4, 64'h8000_0400,         4));
        vecs.push_back(mk("req8",      1, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 0,          1,  1, 64'h8000_0500,         0, I4, 64'h8000_0400,         4));
        vecs.push_back(mk("req_top",   0, 0,                     1, 0, 0,            1,  1, TOP,                   0, I4, 64'h8000_0400,         4));
        vecs.push_back(mk("wait_top",  0, 0,                     0, 1, I5,           1,  0, 0,                     0, I4, 64'h8000_0400,         4));
        vecs.push_back(mk("hold_top",  0, 0,                     0, 0, 0,            1,  0, 0,                     1, I5, TOP,                   4));
        vecs.push_back(mk("req_wrap",  0, 0,                     0, 0, 0,            1,  1, 64'h0,                 0, I5, TOP,                   5));
        vecs.push_back(mk("req_last",  0, 0,                     1, 0, 0,            1,  1, 64'h0,                 0, I5, TOP,                   5));

        @(negedge clk);
        #1;
        check_outputs("reset", 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Now sitting in WAIT; pull reset asynchronously in the middle of the low phase.
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_outputs("async_rst", 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 64'h0);
        @(negedge clk);
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h0BAD_0BAD;
        #1;
        check_outputs("in_rst", 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        apply_vec(mk("boot2_stale", 0, 0, 0, 1, 32'h0BAD_0BAD, 1, 0, 0,             0, 0,  0,             0));
        apply_vec(mk("req_boot2",   0, 0, 1, 0, 0,             1, 1, 64'h8000_0000, 0, 0,  0,             0));
        apply_vec(mk("wait_boot2",  0, 0, 0, 1, I0,            1, 0, 0,             0, 0,  0,             0));
        apply_vec(mk("hold_boot2",  0, 0, 0, 0, 0,             1, 0, 0,             1, I0, 64'h8000_0000, 0));
        apply_vec(mk("req_after",   0, 0, 0, 0, 0,             1, 1, 64'h8000_0004, 0, I0, 64'h8000_0000, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
